// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared types and constants for the two-port SRAM arbiter.
//   state_t  : sequencer state encoding (IDLE, ACCESS, RESP)
//   SRAM_*   : default macro geometry (word address, data and strobe widths)
//   WSTRB_RD : strobe value that marks a read
package sram_arb_pkg;

   localparam int unsigned SRAM_AW = 10;
   localparam int unsigned SRAM_DW = 32;
   localparam int unsigned SRAM_SW = 4;

   localparam logic [SRAM_SW-1:0] WSTRB_RD = 4'h0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/sram_arb_gnt.sv
// sram_arb_gnt: picks the winner between two requesters.
// Build option SRAM_ARB_RR_EN: round-robin on ties using a last-grant pointer
// (reset to 1 so m0 wins the first tie). Without it, fixed priority to m0 and
// no pointer register exists.
// Ports:
//   clk_i, rst_n_i : clock, async active-low reset (pointer only)
//   m0_valid_i     : requester 0 valid
//   m1_valid_i     : requester 1 valid
//   upd_i          : a grant is being taken this cycle (pointer update)
//   req_c          : any requester valid (combinational)
//   gnt_c          : winner, 0 = m0, 1 = m1 (combinational)
module sram_arb_gnt (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic m0_valid_i,
   input  logic m1_valid_i,
   input  logic upd_i,
   output logic req_c,
   output logic gnt_c
);

   assign req_c = m0_valid_i | m1_valid_i;

`ifdef SRAM_ARB_RR_EN
   logic ptr_q;

   // Last-grant pointer
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ptr_q <= 1'b1;
      end else if (upd_i) begin
         ptr_q <= gnt_c;
      end
   end

   // On a tie the master that was not granted last wins
   always_comb begin
      gnt_c = 1'b0;
      if (m0_valid_i && m1_valid_i) begin
         gnt_c = ~ptr_q;
      end else if (m1_valid_i) begin
         gnt_c = 1'b1;
      end
   end
`else
   // Clock, reset and update only feed the pointer, which this build omits
   logic unused_ok;
   assign unused_ok = ^{clk_i, rst_n_i, upd_i};

   // m0 always wins ties; m1 wins only when alone
   assign gnt_c = ~m0_valid_i & m1_valid_i;
`endif

endmodule

// File: rtl/sram_arb_2p.sv
// sram_arb_2p: two-master valid/ready arbiter and sequencer for the
// single-port 1024x32 SRAM wrapper. One access per three cycles:
// IDLE (arbitrate, latch command) -> ACCESS (macro select) -> RESP (ready).
// Build option SRAM_ARB_RR_EN selects round-robin tie-break (see sram_arb_gnt).
// Ports:
//   clk_i, rst_n_i         : clock, async active-low reset
//   mN_valid_i             : request valid, held until ready
//   mN_addr_i              : byte address, [1:0] ignored
//   mN_wdata_i, mN_wstrb_i : write data and strobes (strobe 0 = read)
//   mN_ready_o             : one-cycle completion pulse
//   mN_rdata_o             : read data, valid with ready
//   sram_cs_o, sram_addr_o, sram_data_o, sram_mask_o, sram_wren_o : macro command
//   sram_rdata_i           : macro read data, valid the cycle after a read
module sram_arb_2p
   import sram_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = SRAM_AW,
   parameter int unsigned DATA_WIDTH = SRAM_DW
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,

   input  logic                      m0_valid_i,
   input  logic [ADDR_WIDTH+1:0]     m0_addr_i,
   input  logic [DATA_WIDTH-1:0]     m0_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]   m0_wstrb_i,
   output logic                      m0_ready_o,
   output logic [DATA_WIDTH-1:0]     m0_rdata_o,

   input  logic                      m1_valid_i,
   input  logic [ADDR_WIDTH+1:0]     m1_addr_i,
   input  logic [DATA_WIDTH-1:0]     m1_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]   m1_wstrb_i,
   output logic                      m1_ready_o,
   output logic [DATA_WIDTH-1:0]     m1_rdata_o,

   output logic                      sram_cs_o,
   output logic [ADDR_WIDTH-1:0]     sram_addr_o,
   output logic [DATA_WIDTH-1:0]     sram_data_o,
   output logic [DATA_WIDTH/8-1:0]   sram_mask_o,
   output logic                      sram_wren_o,
   input  logic [DATA_WIDTH-1:0]     sram_rdata_i
);

   localparam int unsigned SW = DATA_WIDTH / 8;

   state_t                state_q, state_d;
   logic                  gnt_q, gnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [SW-1:0]         strb_q, strb_d;
   logic                  cs_q, cs_d;
   logic                  wren_q, wren_d;
   logic [SW-1:0]         mask_q, mask_d;
   logic                  m0_rdy_q, m0_rdy_d;
   logic                  m1_rdy_q, m1_rdy_d;
   logic                  rd_q, rd_d;

   logic                  req_c;
   logic                  gnt_c;
   logic                  upd_c;
   logic [ADDR_WIDTH-1:0] win_addr_c;
   logic [DATA_WIDTH-1:0] win_data_c;
   logic [SW-1:0]         win_strb_c;

   // Byte offset bits are not used by a word-wide macro
   logic unused_ok;
   assign unused_ok = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

   // Winner selection
   sram_arb_gnt u_gnt (
      .clk_i      (clk_i),
      .rst_n_i    (rst_n_i),
      .m0_valid_i (m0_valid_i),
      .m1_valid_i (m1_valid_i),
      .upd_i      (upd_c),
      .req_c      (req_c),
      .gnt_c      (gnt_c)
   );

   // Winner's command fields
   always_comb begin
      win_addr_c = gnt_c ? m1_addr_i[ADDR_WIDTH+1:2] : m0_addr_i[ADDR_WIDTH+1:2];
      win_data_c = gnt_c ? m1_wdata_i : m0_wdata_i;
      win_strb_c = gnt_c ? m1_wstrb_i : m0_wstrb_i;
   end

   // State and output registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         gnt_q    <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         strb_q   <= '0;
         cs_q     <= 1'b0;
         wren_q   <= 1'b0;
         mask_q   <= '0;
         m0_rdy_q <= 1'b0;
         m1_rdy_q <= 1'b0;
         rd_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         strb_q   <= strb_d;
         cs_q     <= cs_d;
         wren_q   <= wren_d;
         mask_q   <= mask_d;
         m0_rdy_q <= m0_rdy_d;
         m1_rdy_q <= m1_rdy_d;
         rd_q     <= rd_d;
      end
   end

   // Next state and next register values; macro strobes are set up one edge
   // ahead so they are high exactly while the FSM sits in ACCESS, and ready
   // likewise for RESP
   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      addr_d   = addr_q;
      data_d   = data_q;
      strb_d   = strb_q;
      cs_d     = 1'b0;
      wren_d   = 1'b0;
      mask_d   = '0;
      m0_rdy_d = 1'b0;
      m1_rdy_d = 1'b0;
      rd_d     = 1'b0;
      upd_c    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_c) begin
               state_d = ACCESS;
               upd_c   = 1'b1;
               gnt_d   = gnt_c;
               addr_d  = win_addr_c;
               data_d  = win_data_c;
               strb_d  = win_strb_c;
               cs_d    = 1'b1;
               wren_d  = (win_strb_c != SW'(WSTRB_RD));
               mask_d  = (win_strb_c != SW'(WSTRB_RD)) ? win_strb_c : '0;
            end
         end
         ACCESS: begin
            state_d  = RESP;
            m0_rdy_d = ~gnt_q;
            m1_rdy_d = gnt_q;
            rd_d     = (strb_q == SW'(WSTRB_RD));
         end
         RESP: begin
            // Mandatory gap: an old valid still high here is not re-granted
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign sram_cs_o   = cs_q;
   assign sram_wren_o = wren_q;
   assign sram_mask_o = mask_q;
   assign sram_addr_o = addr_q;
   assign sram_data_o = data_q;

   assign m0_ready_o  = m0_rdy_q;
   assign m1_ready_o  = m1_rdy_q;

   // Macro data arrives in RESP, so it is steered rather than registered
   assign m0_rdata_o  = (m0_rdy_q && rd_q) ? sram_rdata_i : '0;
   assign m1_rdata_o  = (m1_rdy_q && rd_q) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_sram_arb_2p.sv
// tb_sram_arb_2p: scoreboard bench for sram_arb_2p with a behavioural SRAM.
// Honours SRAM_ARB_RR_EN for the expected grant order under contention.
module tb_sram_arb_2p;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;

   logic        m0_valid = 1'b0, m1_valid = 1'b0;
   logic [11:0] m0_addr = '0, m1_addr = '0;
   logic [31:0] m0_wdata = '0, m1_wdata = '0;
   logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
   logic        m0_ready, m1_ready;
   logic [31:0] m0_rdata, m1_rdata;

   logic        sram_cs, sram_wren;
   logic [9:0]  sram_addr;
   logic [31:0] sram_wdata;
   logic [3:0]  sram_mask;
   logic [31:0] sram_rdata = '0;

   always #5 clk = ~clk;

   sram_arb_2p dut (
      .clk_i        (clk),
      .rst_n_i      (rst_n),
      .m0_valid_i   (m0_valid),
      .m0_addr_i    (m0_addr),
      .m0_wdata_i   (m0_wdata),
      .m0_wstrb_i   (m0_wstrb),
      .m0_ready_o   (m0_ready),
      .m0_rdata_o   (m0_rdata),
      .m1_valid_i   (m1_valid),
      .m1_addr_i    (m1_addr),
      .m1_wdata_i   (m1_wdata),
      .m1_wstrb_i   (m1_wstrb),
      .m1_ready_o   (m1_ready),
      .m1_rdata_o   (m1_rdata),
      .sram_cs_o    (sram_cs),
      .sram_addr_o  (sram_addr),
      .sram_data_o  (sram_wdata),
      .sram_mask_o  (sram_mask),
      .sram_wren_o  (sram_wren),
      .sram_rdata_i (sram_rdata)
   );

   // Behavioural single-port SRAM: read data appears the cycle after select
   logic [31:0] mem [0:1023];
   always @(posedge clk) begin
      if (sram_cs) begin
         if (sram_wren) begin
            for (int b = 0; b < 4; b++)
               if (sram_mask[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         end else begin
            sram_rdata <= mem[sram_addr];
         end
      end
   end

   typedef struct {
      logic [9:0]  addr;
      logic        wren;
      logic [3:0]  mask;
      logic [31:0] data;
   } cmd_t;

   typedef struct {
      int          m;
      logic [31:0] rdata;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   cmd_t mon_c;
   rsp_t mon_r;
   int   checks = 0;
   int   errors = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
      end
   endfunction

   // Push the SRAM command and master response one transaction should produce
   function automatic void expect_op(int m, logic [11:0] a, logic [31:0] d,
                                     logic [3:0] s, logic [31:0] rd);
      cmd_t c;
      rsp_t r;
      c.addr  = a[11:2];
      c.wren  = (s != 4'h0);
      c.mask  = s;
      c.data  = d;
      r.m     = m;
      r.rdata = (s != 4'h0) ? 32'h0 : rd;
      cmd_q.push_back(c);
      rsp_q.push_back(r);
   endfunction

   // SRAM command monitor
   always @(negedge clk) begin
      if (sram_cs) begin
         if (cmd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sram_unexpected: access at word 0x%03h, want no access", sram_addr);
         end else begin
            mon_c = cmd_q.pop_front();
            chk("sram_addr", 32'(sram_addr), 32'(mon_c.addr));
            chk("sram_wren", 32'(sram_wren), 32'(mon_c.wren));
            chk("sram_mask", 32'(sram_mask), 32'(mon_c.mask));
            chk("sram_data", sram_wdata, mon_c.data);
         end
      end else begin
         chk("sram_idle_wren", 32'(sram_wren), 32'h0);
         chk("sram_idle_mask", 32'(sram_mask), 32'h0);
      end
   end

   // Response monitor
   always @(negedge clk) begin
      if (m0_ready || m1_ready) begin
         if (rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: ready m0=%0b m1=%0b, want none", m0_ready, m1_ready);
         end else begin
            mon_r = rsp_q.pop_front();
            chk("rsp_m0_ready", 32'(m0_ready), (mon_r.m == 0) ? 32'h1 : 32'h0);
            chk("rsp_m1_ready", 32'(m1_ready), (mon_r.m == 1) ? 32'h1 : 32'h0);
            chk("rsp_m0_rdata", m0_rdata, (mon_r.m == 0) ? mon_r.rdata : 32'h0);
            chk("rsp_m1_rdata", m1_rdata, (mon_r.m == 1) ? mon_r.rdata : 32'h0);
         end
      end
   end

   task automatic drive(input int m, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s);
      if (m == 0) begin
         m0_valid = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = s;
      end else begin
         m1_valid = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = s;
      end
   endtask

   task automatic drop(input int m);
      if (m == 0) m0_valid = 1'b0;
      else        m1_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   // Wait for the master's ready; optionally check latency and select timing
   task automatic wait_rdy(input int m, input int lat, input bit cs_chk, input string name);
      int cnt = 0;
      bit got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         @(posedge clk); #1;
         cnt++;
         if (cs_chk && cnt == 1) chk({name, "_cs"}, 32'(sram_cs), 32'h1);
         if ((m == 0) ? m0_ready : m1_ready) got = 1'b1;
      end
      if (!got) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: no ready in 60 cycles, want ready", name);
      end else if (lat > 0) begin
         chk({name, "_lat"}, 32'(cnt), 32'(lat));
      end
   endtask

   task automatic xfer(input int m, input logic [11:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int lat, input string name);
      drive(m, a, d, s);
      wait_rdy(m, lat, lat > 0, name);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_cs"},    32'(sram_cs),   32'h0);
      chk({name, "_wren"},  32'(sram_wren), 32'h0);
      chk({name, "_mask"},  32'(sram_mask), 32'h0);
      chk({name, "_addr"},  32'(sram_addr), 32'h0);
      chk({name, "_data"},  sram_wdata,     32'h0);
      chk({name, "_rdy0"},  32'(m0_ready),  32'h0);
      chk({name, "_rdy1"},  32'(m1_ready),  32'h0);
      chk({name, "_rd0"},   m0_rdata,       32'h0);
      chk({name, "_rd1"},   m1_rdata,       32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      #1 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Contention: both masters continuously valid, four writes each
`ifdef SRAM_ARB_RR_EN
      for (int i = 0; i < 4; i++) begin
         expect_op(0, 12'(12'h200 + 4*i), 32'(32'hA0 + i), 4'hF, 32'h0);
         expect_op(1, 12'(12'h300 + 4*i), 32'(32'hB0 + i), 4'hF, 32'h0);
      end
`else
      for (int i = 0; i < 4; i++)
         expect_op(0, 12'(12'h200 + 4*i), 32'(32'hA0 + i), 4'hF, 32'h0);
      for (int i = 0; i < 4; i++)
         expect_op(1, 12'(12'h300 + 4*i), 32'(32'hB0 + i), 4'hF, 32'h0);
`endif
      fork
         begin
            for (int i = 0; i < 4; i++)
               xfer(0, 12'(12'h200 + 4*i), 32'(32'hA0 + i), 4'hF, 0, "cont_m0");
            drop(0);
         end
         begin
            for (int j = 0; j < 4; j++)
               xfer(1, 12'(12'h300 + 4*j), 32'(32'hB0 + j), 4'hF, 0, "cont_m1");
            drop(1);
         end
      join

      // Full-word write then read back, checking k+1 select and k+2 ready
      expect_op(0, 12'h100, 32'hDEADBEEF, 4'hF, 32'h0);
      xfer(0, 12'h100, 32'hDEADBEEF, 4'hF, 2, "wr100");
      drop(0);
      expect_op(0, 12'h100, 32'h0, 4'h0, 32'hDEADBEEF);
      xfer(0, 12'h100, 32'h0, 4'h0, 2, "rd100");
      drop(0);

      // Byte-lane write merges into existing word
      expect_op(0, 12'h104, 32'h11223344, 4'hF, 32'h0);
      xfer(0, 12'h104, 32'h11223344, 4'hF, 2, "wr104");
      drop(0);
      expect_op(0, 12'h104, 32'h000000AA, 4'h1, 32'h0);
      xfer(0, 12'h104, 32'h000000AA, 4'h1, 2, "wrb104");
      drop(0);
      expect_op(0, 12'h104, 32'h0, 4'h0, 32'h112233AA);
      xfer(0, 12'h104, 32'h0, 4'h0, 2, "rd104");
      drop(0);

      // m1 alone at the top word
      expect_op(1, 12'hFFC, 32'hCAFEF00D, 4'hF, 32'h0);
      xfer(1, 12'hFFC, 32'hCAFEF00D, 4'hF, 2, "wrffc");
      drop(1);
      expect_op(1, 12'hFFC, 32'h0, 4'h0, 32'hCAFEF00D);
      xfer(1, 12'hFFC, 32'h0, 4'h0, 2, "rdffc");
      drop(1);

      // Reset during ACCESS, valid held through reset
      drive(0, 12'h104, 32'h0, 4'h0);
      @(posedge clk); #1;
      chk("rst_pre_cs", 32'(sram_cs), 32'h1);
      #1 rst_n = 1'b0;
      #1 chk_all_zero("rst_mid");
      repeat (2) @(posedge clk);
      #3;
      expect_op(0, 12'h104, 32'h0, 4'h0, 32'h112233AA);
      rst_n = 1'b1;
      wait_rdy(0, 2, 1'b1, "rst_regrant");
      drop(0);

      // Valid dropped during ACCESS: completes once, no second access
      expect_op(0, 12'h100, 32'h0, 4'h0, 32'hDEADBEEF);
      drive(0, 12'h100, 32'h0, 4'h0);
      @(posedge clk); #1;
      chk("drop_cs", 32'(sram_cs), 32'h1);
      m0_valid = 1'b0;
      wait_rdy(0, 1, 1'b0, "drop");
      repeat (6) @(posedge clk);
      #1;

      chk("cmd_q_empty", 32'(cmd_q.size()), 32'h0);
      chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
